// File: rtl/scaler_h_ctrl.sv
// Sequencing/configuration front end for scaler_h: forwards only whole frames,
// applies scale-step changes in vertical blank and measures line widths.
module scaler_h_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_WIDTH = 16,
    parameter int STEP_INIT  = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STEP_WIDTH-1:0] cfg_scale_step,
    input  logic                  cfg_wr,
    output logic                  cfg_pending_o,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [STEP_WIDTH-1:0] scale_step_o,
    input  logic                  sc_de_i,
    input  logic                  sc_hs_i,
    output logic [CNT_WIDTH-1:0]  stat_in_width_o,
    output logic [CNT_WIDTH-1:0]  stat_out_width_o,
    output logic [CNT_WIDTH-1:0]  stat_frame_cnt_o,
    output logic                  frame_done_o,
    output logic                  err_width_o,
    output logic [1:0]            dbg_state_o
);

    // Stream handshake: there is no back-pressure; a pixel is transferred in
    // every cycle where de is high, and de_o follows de_i by exactly one cycle.

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_SYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:   if (vs_i)  state_d = ST_VBLANK;
            ST_VBLANK: if (!vs_i) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vs_i)  state_d = ST_VBLANK;
            default:   state_d = ST_SYNC;
        endcase
    end

    assign dbg_state_o = state_q;

    // Gating follows the next state, so the first vs_i = 0 cycle is forwarded.
    logic fwd_act, fwd_sync, frame_end, apply, in_act, hs_rise, sc_rise;
    assign fwd_act   = (state_d == ST_ACTIVE);
    assign fwd_sync  = (state_d == ST_SYNC);
    assign frame_end = (state_q == ST_ACTIVE) && vs_i;
    assign apply     = (state_q == ST_VBLANK) && cfg_pending_o;

    logic [DATA_WIDTH-1:0] do_q;
    logic                  de_q, hs_q, vs_q;
    logic [STEP_WIDTH-1:0] step_q, step_d, pend_val_q, pend_val_d;
    logic                  pend_q, pend_d;
    logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d, in_ref_q, in_ref_d, in_width_q, in_width_d;
    logic                  first_q, first_d, hs_prev_q, err_q, err_d, mismatch;
    logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d, out_width_q, out_width_d;
    logic                  sc_hs_prev_q;
    logic [CNT_WIDTH-1:0]  frame_cnt_q;
    logic                  frame_done_q;

    // The last input line of a frame may end in the cycle vs_i rises, so the
    // width check spans both the current and the next state being ACTIVE.
    assign in_act  = (state_q == ST_ACTIVE) || fwd_act;
    assign hs_rise = hs_i && !hs_prev_q;
    assign sc_rise = sc_hs_i && !sc_hs_prev_q;

    always_comb begin
        step_d     = apply ? pend_val_q : step_q;
        pend_d     = cfg_wr ? 1'b1 : (apply ? 1'b0 : pend_q);
        pend_val_d = cfg_wr ? cfg_scale_step : pend_val_q;
    end

    always_comb begin
        in_cnt_d   = in_cnt_q;
        in_ref_d   = in_ref_q;
        in_width_d = in_width_q;
        first_d    = first_q;
        mismatch   = 1'b0;
        if (!in_act) begin
            in_cnt_d = '0;
            first_d  = 1'b1;
        end else if (hs_rise) begin
            in_cnt_d = '0;
            if (in_cnt_q != '0) begin
                in_width_d = in_cnt_q;
                first_d    = 1'b0;
                if (first_q)                   in_ref_d = in_cnt_q;
                else if (in_cnt_q != in_ref_q) mismatch = 1'b1;
            end
        end else if (de_i && (in_cnt_q != '1)) begin
            in_cnt_d = in_cnt_q + 1'b1;
        end
        err_d = mismatch ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_comb begin
        out_cnt_d   = out_cnt_q;
        out_width_d = out_width_q;
        if (sc_rise) begin
            out_cnt_d = '0;
            if (out_cnt_q != '0) out_width_d = out_cnt_q;
        end else if (sc_hs_i) begin
            out_cnt_d = '0;
        end else if (sc_de_i && (out_cnt_q != '1)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_q         <= '0;
            de_q         <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            step_q       <= STEP_WIDTH'(STEP_INIT);
            pend_q       <= 1'b0;
            pend_val_q   <= '0;
            in_cnt_q     <= '0;
            in_ref_q     <= '0;
            in_width_q   <= '0;
            first_q      <= 1'b1;
            hs_prev_q    <= 1'b1;
            err_q        <= 1'b0;
            out_cnt_q    <= '0;
            out_width_q  <= '0;
            sc_hs_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            do_q         <= fwd_act ? di_i : '0;
            de_q         <= fwd_act && de_i;
            hs_q         <= fwd_sync ? 1'b1 : hs_i;
            vs_q         <= fwd_sync ? 1'b1 : vs_i;
            step_q       <= step_d;
            pend_q       <= pend_d;
            pend_val_q   <= pend_val_d;
            in_cnt_q     <= in_cnt_d;
            in_ref_q     <= in_ref_d;
            in_width_q   <= in_width_d;
            first_q      <= first_d;
            hs_prev_q    <= hs_i;
            err_q        <= err_d;
            out_cnt_q    <= out_cnt_d;
            out_width_q  <= out_width_d;
            sc_hs_prev_q <= sc_hs_i;
            frame_cnt_q  <= frame_end ? frame_cnt_q + 1'b1 : frame_cnt_q;
            frame_done_q <= frame_end;
        end
    end

    assign do_o             = do_q;
    assign de_o             = de_q;
    assign hs_o             = hs_q;
    assign vs_o             = vs_q;
    assign scale_step_o     = step_q;
    assign cfg_pending_o    = pend_q;
    assign stat_in_width_o  = in_width_q;
    assign stat_out_width_o = out_width_q;
    assign stat_frame_cnt_o = frame_cnt_q;
    assign frame_done_o     = frame_done_q;
    assign err_width_o      = err_q;

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Bench for scaler_h_ctrl: random frames against a frame-level reference model,
// with a cycle-stamped scoreboard for forwarded pixels and frame-done pulses.
module tb_scaler_h_ctrl;

    localparam int DW = 8;
    localparam int SW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] cfg_scale_step;
    logic          cfg_wr, cfg_pending_o, err_clr;
    logic [DW-1:0] di_i, do_o;
    logic          de_i, hs_i, vs_i, de_o, hs_o, vs_o;
    logic [SW-1:0] scale_step_o;
    logic          sc_de_i, sc_hs_i;
    logic [CW-1:0] stat_in_width_o, stat_out_width_o, stat_frame_cnt_o;
    logic          frame_done_o, err_width_o;
    logic [1:0]    dbg_state;

    scaler_h_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_scale_step   (cfg_scale_step),
        .cfg_wr           (cfg_wr),
        .cfg_pending_o    (cfg_pending_o),
        .err_clr          (err_clr),
        .di_i             (di_i),
        .de_i             (de_i),
        .hs_i             (hs_i),
        .vs_i             (vs_i),
        .do_o             (do_o),
        .de_o             (de_o),
        .hs_o             (hs_o),
        .vs_o             (vs_o),
        .scale_step_o     (scale_step_o),
        .sc_de_i          (sc_de_i),
        .sc_hs_i          (sc_hs_i),
        .stat_in_width_o  (stat_in_width_o),
        .stat_out_width_o (stat_out_width_o),
        .stat_frame_cnt_o (stat_frame_cnt_o),
        .frame_done_o     (frame_done_o),
        .err_width_o      (err_width_o),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [39:0] exp_q[$];   // {cycle, pixel}
    logic [47:0] fd_q[$];    // {cycle, frame count}
    logic [47:0] mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0][39:8] == cyc) begin
                mon_e = {8'd0, exp_q.pop_front()};
                chk("de_o_slot", {31'd0, de_o}, 32'd1);
                chk("do_o", {24'd0, do_o}, {24'd0, mon_e[7:0]});
            end else if (de_o) begin
                chk("spurious_de_o", {31'd0, de_o}, 32'd0);
            end
            if (fd_q.size() > 0 && fd_q[0][47:16] == cyc) begin
                mon_e = fd_q.pop_front();
                chk("frame_done_slot", {31'd0, frame_done_o}, 32'd1);
                chk("frame_cnt", {16'd0, stat_frame_cnt_o}, {16'd0, mon_e[15:0]});
            end else if (frame_done_o) begin
                chk("spurious_frame_done", {31'd0, frame_done_o}, 32'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_step, m_pend;
    bit          m_pend_v, m_synced, m_fwd, m_in_frame, m_err, m_first;
    int          m_frames, m_last_w, m_last_ow, m_ref;

    task automatic model_reset();
        m_step = 16'd4096; m_pend = 16'd0; m_pend_v = 0;
        m_synced = 0; m_fwd = 0; m_in_frame = 0; m_err = 0; m_first = 1;
        m_frames = 0; m_last_w = 0; m_last_ow = 0; m_ref = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] val);
        cfg_scale_step = val;
        cfg_wr = 1'b1;
        m_pend = val;
        m_pend_v = 1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic vblank(input int n, input bit stats);
        vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0; sc_hs_i = 1'b1; sc_de_i = 1'b0;
        if (m_in_frame) begin
            m_frames = (m_frames + 1) & 16'hffff;
            fd_q.push_back({cyc + 1, 16'(m_frames)});
            m_in_frame = 0;
        end
        m_synced = 1;
        if (m_pend_v) begin
            m_step = m_pend;
            m_pend_v = 0;
        end
        repeat (n) tick();
        chk("vb_scale_step", {16'd0, scale_step_o}, {16'd0, m_step});
        chk("vb_pending", {31'd0, cfg_pending_o}, {31'd0, m_pend_v});
        if (stats) begin
            chk("vb_in_width", {16'd0, stat_in_width_o}, m_last_w);
            chk("vb_out_width", {16'd0, stat_out_width_o}, m_last_ow);
            chk("vb_err", {31'd0, err_width_o}, {31'd0, m_err});
            chk("vb_frame_cnt", {16'd0, stat_frame_cnt_o}, m_frames);
        end
    endtask

    task automatic drive_line(input int w, input int ow);
        int px = 0;
        int gap = 0;
        int c = 0;
        hs_i = 1'b0; vs_i = 1'b0; sc_hs_i = 1'b0;
        while (px < w || c < ow) begin
            de_i = (px < w) && (gap == 0);
            if (de_i) begin
                di_i = DW'($urandom_range(0, 255));
                if (m_fwd) exp_q.push_back({cyc + 1, di_i});
                px++;
                gap = $urandom_range(1, 2);
            end else if (gap > 0) begin
                gap--;
            end
            sc_de_i = (c < ow);
            tick();
            c++;
        end
        hs_i = 1'b1; sc_hs_i = 1'b1; de_i = 1'b0; sc_de_i = 1'b0;
        if (m_fwd) begin
            if (m_first) begin
                m_ref = w;
                m_first = 0;
            end else if (w != m_ref) begin
                m_err = 1;
            end
            m_last_w = w;
        end
        if (ow > 0) m_last_ow = ow;
        repeat ($urandom_range(3, 6)) tick();
        chk("line_err", {31'd0, err_width_o}, {31'd0, m_err});
        chk("line_in_width", {16'd0, stat_in_width_o}, m_last_w);
        chk("line_out_width", {16'd0, stat_out_width_o}, m_last_ow);
    endtask

    task automatic drive_frame(input int lines, input int w, input int bad_line, input int bad_w,
                               input int cfg_line, input int n_cfg, input logic [15:0] c0,
                               input logic [15:0] c1, input int abort_line);
        int lw;
        m_fwd = m_synced;
        m_in_frame = m_fwd;
        m_first = 1;
        for (int l = 0; l < lines; l++) begin
            if (l == abort_line) begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                model_reset();
            end
            lw = (l == bad_line) ? bad_w : w;
            // The bench stands in for the scaler: one output line per input
            // line, of the ideal width for the step in force this frame.
            drive_line(lw, (lw * 4096) / int'(m_step));
            if (l == cfg_line) begin
                if (n_cfg > 0) cfg_write(c0);
                if (n_cfg > 1) cfg_write(c1);
                chk("frozen_step", {16'd0, scale_step_o}, {16'd0, m_step});
                chk("mid_pending", {31'd0, cfg_pending_o}, {31'd0, m_pend_v});
            end
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int lines, w, bad, ab;
        logic [15:0] steps [4];
        steps[0] = 16'd2048; steps[1] = 16'd3072; steps[2] = 16'd4096; steps[3] = 16'd6144;
        model_reset();
        rst = 1'b1; cfg_scale_step = '0; cfg_wr = 1'b0; err_clr = 1'b0;
        di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; sc_de_i = 1'b0; sc_hs_i = 1'b1;

        // Reset with vs_i low and de_i toggling: nothing may be forwarded.
        for (int i = 0; i < 12; i++) begin
            if (i == 4) rst = 1'b0;
            de_i = ~de_i;
            di_i = DW'($urandom_range(0, 255));
            tick();
        end
        de_i = 1'b0;
        chk("rst_de_o", {31'd0, de_o}, 32'd0);
        chk("rst_hs_o", {31'd0, hs_o}, 32'd1);
        chk("rst_vs_o", {31'd0, vs_o}, 32'd1);
        chk("rst_step", {16'd0, scale_step_o}, 32'd4096);
        chk("rst_pending", {31'd0, cfg_pending_o}, 32'd0);
        chk("rst_in_width", {16'd0, stat_in_width_o}, 32'd0);
        chk("rst_out_width", {16'd0, stat_out_width_o}, 32'd0);
        chk("rst_frame_cnt", {16'd0, stat_frame_cnt_o}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
        chk("rst_err", {31'd0, err_width_o}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        vblank(6, 0);
        drive_frame(25, 25, -1, 0, -1, 0, 16'd0, 16'd0, -1);
        vblank(6, 1);
        drive_frame(25, 25, -1, 0, 12, 1, 16'd2048, 16'd0, -1);
        vblank(6, 1);
        drive_frame(25, 25, -1, 0, 5, 2, 16'd8192, 16'd3072, -1);
        vblank(6, 1);
        drive_frame(10, 25, -1, 0, -1, 0, 16'd0, 16'd0, -1);
        vblank(6, 1);

        // cfg_wr landing in the very cycle the previous write is applied.
        cfg_scale_step = 16'd5000; cfg_wr = 1'b1;
        tick();
        cfg_scale_step = 16'd2048;
        tick();
        cfg_wr = 1'b0;
        chk("race_old_applied", {16'd0, scale_step_o}, 32'd5000);
        chk("race_new_pending", {31'd0, cfg_pending_o}, 32'd1);
        tick();
        chk("race_new_applied", {16'd0, scale_step_o}, 32'd2048);
        chk("race_pending_clear", {31'd0, cfg_pending_o}, 32'd0);
        m_step = 16'd2048; m_pend = 16'd2048; m_pend_v = 0;

        drive_frame(25, 25, 2, 24, -1, 0, 16'd0, 16'd0, -1);
        vblank(6, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 0;
        tick();
        chk("err_cleared", {31'd0, err_width_o}, 32'd0);
        drive_frame(25, 25, -1, 0, -1, 0, 16'd0, 16'd0, -1);
        vblank(6, 1);

        for (int r = 0; r < 5; r++) begin
            lines = $urandom_range(3, 6);
            w     = $urandom_range(4, 20);
            bad   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lines - 1) : -1;
            ab    = (r == 2) ? 1 : -1;
            drive_frame(lines, w, bad, w - 1, (r == 2) ? -1 : 0, $urandom_range(0, 2),
                        steps[$urandom_range(0, 3)], steps[$urandom_range(0, 3)], ab);
            vblank($urandom_range(4, 8), 1);
            if (m_err) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                m_err = 0;
                tick();
                chk("rand_err_clr", {31'd0, err_width_o}, 32'd0);
            end
        end

        repeat (4) tick();
        chk("pix_queue_drained", exp_q.size(), 32'd0);
        chk("fd_queue_drained", fd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
